// File: rtl/stage_pipeline_if.sv
// rtl/stage_pipeline_if.sv - handshake, flush and occupancy bundle for stage_pipeline
interface stage_pipeline_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
);
  localparam int CW = $clog2(STAGES + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  // slave is the pipeline itself; master is the producer/consumer environment
  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output count
  );

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  count
  );
endinterface

// File: rtl/stage_pipeline.sv
// rtl/stage_pipeline.sv - STAGES-deep valid/ready pipeline adding STEP per stage
module stage_pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int STEP   = 1
) (
  input  logic           clk,
  input  logic           rst,
  stage_pipeline_if.slave io
);
  localparam int               CW     = $clog2(STAGES + 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [CW-1:0]     count_q, count_d;

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  up_d [STAGES];

  // Ready ripples back from the consumer; an empty stage is always ready,
  // which is what lets bubbles collapse.
  always_comb begin
    logic r;
    r = io.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !v_q[k] || r;
      rdy[k] = r;
    end
  end

  always_comb begin
    up_v[0] = io.in_valid;
    up_d[0] = io.in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_v[k] = v_q[k-1];
      up_d[k] = d_q[k-1];
    end
  end

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (rdy[k]) begin
        v_d[k] = up_v[k];
        d_d[k] = up_d[k] + STEP_W;
      end
    end
    // Flush drops every valid; data registers are left stale on purpose.
    if (io.flush) begin
      v_d = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      count_d = count_d + CW'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign io.in_ready  = rdy[0] && !io.flush && !rst;
  assign io.out_valid = v_q[STAGES-1];
  assign io.out_data  = d_q[STAGES-1];
  assign io.count     = count_q;
endmodule
